// File: rtl/clk_offset_adjust.sv
// Multi-channel modulo time-offset register bank stepped by up/down buttons,
// with hold-to-repeat and a both-buttons lockout.
module clk_offset_adjust #(
  parameter int NCH           = 2,
  parameter int W             = 11,
  parameter int MOD           = 1440,
  parameter int HOLD_DELAY    = 4,
  parameter int REPEAT_PERIOD = 2,
  localparam int SW           = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             userclock,
  input  logic             reset,
  input  logic             adj_en,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic [SW-1:0]    chan_sel,
  output logic [NCH*W-1:0] os_flat,
  output logic             step_pulse,
  output logic             repeating
);

  localparam int CMAX = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [W-1:0] MAX_V = W'(MOD - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2,
    LOCK   = 2'd3
  } state_t;

  function automatic logic [W-1:0] step_inc(input logic [W-1:0] v);
    return (v == MAX_V) ? {W{1'b0}} : v + W'(1);
  endfunction

  function automatic logic [W-1:0] step_dec(input logic [W-1:0] v);
    return (v == {W{1'b0}}) ? MAX_V : v - W'(1);
  endfunction

  logic          u_q;
  logic          d_q;
  logic          e_q;
  state_t        state_r;
  state_t        state_next_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_next_s;
  logic          dir_r;
  logic          dir_next_s;
  logic          step_s;
  logic          single_s;
  logic          both_s;
  logic          held_s;
  logic          chan_valid_s;
  logic          apply_s;
  logic          step_pulse_r;
  logic          repeating_r;
  logic [W-1:0]  os_r [NCH];

  assign single_s     = u_q ^ d_q;
  assign both_s       = u_q & d_q;
  // A hold continues only with the same single button and adjust mode still on.
  assign held_s       = e_q & single_s & (u_q == dir_r);
  assign chan_valid_s = ({1'b0, chan_sel} < (SW + 1)'(NCH));
  assign apply_s      = step_s & chan_valid_s;

  // Input synchronising registers; the FSM only ever sees these.
  always_ff @(posedge userclock or posedge reset) begin
    if (reset) begin
      u_q <= 1'b0;
      d_q <= 1'b0;
      e_q <= 1'b0;
    end else begin
      u_q <= btn_up;
      d_q <= btn_down;
      e_q <= adj_en;
    end
  end

  // FSM, hold counter and step direction registers.
  always_ff @(posedge userclock or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
      dir_r   <= 1'b0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      dir_r   <= dir_next_s;
    end
  end

  // Next-state, counter and step-request decode.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    dir_next_s   = dir_r;
    step_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (both_s) begin
          state_next_s = LOCK;
        end else if (e_q && single_s) begin
          step_s       = 1'b1;
          dir_next_s   = u_q;
          state_next_s = HOLD;
          cnt_next_s   = CW'(1);
        end else begin
          state_next_s = IDLE;
        end
      end
      HOLD: begin
        if (both_s) begin
          state_next_s = LOCK;
        end else if (held_s) begin
          if (cnt_r == CW'(HOLD_DELAY)) begin
            step_s       = 1'b1;
            state_next_s = REPEAT;
            cnt_next_s   = CW'(1);
          end else begin
            cnt_next_s   = cnt_r + CW'(1);
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      REPEAT: begin
        if (both_s) begin
          state_next_s = LOCK;
        end else if (held_s) begin
          if (cnt_r == CW'(REPEAT_PERIOD)) begin
            step_s     = 1'b1;
            cnt_next_s = CW'(1);
          end else begin
            cnt_next_s = cnt_r + CW'(1);
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      LOCK: begin
        if (!u_q && !d_q) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = LOCK;
        end
      end
      default: begin
        state_next_s = IDLE;
        cnt_next_s   = {CW{1'b0}};
      end
    endcase
  end

  // Registered strobe and repeat indicator, aligned with the offset update.
  always_ff @(posedge userclock or posedge reset) begin
    if (reset) begin
      step_pulse_r <= 1'b0;
      repeating_r  <= 1'b0;
    end else begin
      step_pulse_r <= apply_s;
      repeating_r  <= (state_next_s == REPEAT);
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    localparam logic [SW-1:0] IDX = SW'(g);

    // Per-channel offset register; only the selected channel moves.
    always_ff @(posedge userclock or posedge reset) begin
      if (reset) begin
        os_r[g] <= {W{1'b0}};
      end else if (apply_s && (chan_sel == IDX)) begin
        os_r[g] <= u_q ? step_inc(os_r[g]) : step_dec(os_r[g]);
      end else begin
        os_r[g] <= os_r[g];
      end
    end

    assign os_flat[g*W +: W] = os_r[g];
  end

  assign step_pulse = step_pulse_r;
  assign repeating  = repeating_r;

endmodule
